// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial N-bit subtractor (in1 - in2 - bin), LSB first, one
//            full-subtractor cell with a registered borrow, valid/ready I/O.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         overflow
);

    localparam int                 c_CNT_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N-1:0]         r_a;
    logic [N-1:0]         r_b;
    logic                 r_br;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [N-1:0]         r_sr;
    logic                 r_a_msb;
    logic                 r_b_msb;
    logic [N-1:0]         r_diff;
    logic                 r_bout;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_d;
    logic                 w_br_nxt;
    logic [N-1:0]         w_sr_nxt;

    // The single full-subtractor cell
    assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_sr_nxt = {w_d, r_sr[N-1:1]};
    assign w_last   = (r_cnt == c_LAST);
    assign w_accept = start_valid && (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs decode state only, so they carry no input-to-output path
    always_comb begin
        w_state_nxt = r_state;
        start_ready = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in1;
            r_b     <= in2;
            r_br    <= bin;
            r_cnt   <= '0;
            r_a_msb <= in1[N-1];
            r_b_msb <= in2[N-1];
        end else if (r_state == BUSY) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_nxt;
            r_sr  <= w_sr_nxt;
            r_cnt <= r_cnt + c_CNT_W'(1);
            // Output registers only move on the edge that enters DONE
            if (w_last) begin
                r_diff <= w_sr_nxt;
                r_bout <= w_br_nxt;
                r_ovf  <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
            end
        end
    end

    assign diff     = r_diff;
    assign bout     = r_bout;
    assign overflow = r_ovf;

endmodule
`default_nettype wire
